// File: rtl/gpio_wb_irq.sv
// Wishbone GPIO with per-pin direction, atomic set/clear/toggle,
// two-flop input sync and per-pin edge interrupts with W1C status.
module gpio_wb_irq #(
  parameter logic [31:0] BASE_ADDR = 32'h3002_0000,
  parameter int unsigned NGPIO     = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  input  logic [3:0]       wbs_sel_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] gpio_out,
  output logic [NGPIO-1:0] gpio_oeb,
  output logic             irq_o
);

  localparam int N = NGPIO;

  logic [N-1:0] out_q, out_d;
  logic [N-1:0] oe_q, oe_d;
  logic [N-1:0] ren_q, ren_d;
  logic [N-1:0] fen_q, fen_d;
  logic [N-1:0] sts_q, sts_d;
  logic [N-1:0] s1_q, s2_q, s3_q;
  logic [N-1:0] ev;
  logic [N-1:0] bm;
  logic [N-1:0] wd;
  logic         ack_q;
  logic         irq_q;
  logic [31:0]  dat_q;
  logic [31:0]  rdata;
  logic [31:0]  bmask;
  logic [31:0]  wd32;
  logic [3:0]   idx;
  logic         hit;
  logic         req;
  logic         wr;
  logic         unused_ok;

  assign hit   = wbs_adr_i[31:6] == BASE_ADDR[31:6];
  assign req   = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr    = req & wbs_we_i;
  assign idx   = wbs_adr_i[5:2];
  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                  {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wd32  = wbs_dat_i & bmask;
  assign wd    = wd32[N-1:0];
  assign bm    = bmask[N-1:0];

  assign unused_ok = ^{wbs_adr_i[1:0], wd32, bmask, BASE_ADDR[5:0]};

  // Edge detect runs always; enables only gate status setting.
  assign ev = (s2_q & ~s3_q & ren_q) | (~s2_q & s3_q & fen_q);

  always_comb begin
    out_d = out_q;
    oe_d  = oe_q;
    ren_d = ren_q;
    fen_d = fen_q;
    sts_d = sts_q;
    if (wr) begin
      unique case (idx)
        4'h0: out_d = (out_q & ~bm) | wd;
        4'h1: out_d = out_q | wd;
        4'h2: out_d = out_q & ~wd;
        4'h3: out_d = out_q ^ wd;
        4'h4: oe_d  = (oe_q & ~bm) | wd;
        4'h6: ren_d = (ren_q & ~bm) | wd;
        4'h7: fen_d = (fen_q & ~bm) | wd;
        4'h8: sts_d = sts_q & ~wd;
        default: ;
      endcase
    end
    // A new event beats a same-cycle W1C.
    sts_d = sts_d | ev;
  end

  always_comb begin
    rdata = '0;
    unique case (idx)
      4'h0: rdata[N-1:0] = out_q;
      4'h4: rdata[N-1:0] = oe_q;
      4'h5: rdata[N-1:0] = s2_q;
      4'h6: rdata[N-1:0] = ren_q;
      4'h7: rdata[N-1:0] = fen_q;
      4'h8: rdata[N-1:0] = sts_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q <= '0;
      oe_q  <= '0;
      ren_q <= '0;
      fen_q <= '0;
      sts_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      ack_q <= 1'b0;
      dat_q <= '0;
      irq_q <= 1'b0;
    end else begin
      out_q <= out_d;
      oe_q  <= oe_d;
      ren_q <= ren_d;
      fen_q <= fen_d;
      sts_q <= sts_d;
      s1_q  <= gpio_in;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
      ack_q <= req;
      if (req) dat_q <= rdata;
      irq_q <= |sts_q;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign gpio_out  = out_q;
  assign gpio_oeb  = ~oe_q;
  assign irq_o     = irq_q;

endmodule
